processor_host_controller: RTL and testbench
============================================

# processor_host_controller

Sequencing controller between a host port and the multi-core processor. It arbitrates the shared instruction memory and data memory ports between host transactions (load program, load data, read results) and the processor. It holds the processor in reset between runs and starts a run on host command. It also reports completion, cycle count and a watchdog timeout. It sits between the host interface and the `multi_core_processor` + memory pair.

## Interface
- `REG_WIDTH`, 12, processor register width
- `CORE_COUNT`, 4, number of cores; data word width `DW = REG_WIDTH*CORE_COUNT`
- `INS_WIDTH`, 8, instruction word width
- `INS_MEM_ADDR_WIDTH`, 8, instruction memory address width
- `DATA_MEM_ADDR_WIDTH`, 12, data memory address width
- `TIMEOUT_CYCLES`, 1000000, RUN cycles allowed before abort (≥2)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `host_valid` in 1: host transaction request
- `host_ready` out 1: transaction accepted when `host_valid & host_ready`
- `host_op` in 2: 00 LOAD_INS, 01 LOAD_DATA, 10 RUN, 11 READ_DATA
- `host_addr` in DATA_MEM_ADDR_WIDTH: target address; LOAD_INS uses the low INS_MEM_ADDR_WIDTH bits
- `host_wdata` in DW: write data; LOAD_INS uses the low INS_WIDTH bits
- `host_rdata` out DW: read data
- `host_rvalid` out 1: `host_rdata` valid, one-cycle pulse
- `busy` out 1: high in any state other than IDLE
- `run_done` out 1: sticky; last run ended with `proc_done`
- `run_timeout` out 1: sticky; last run was aborted by the watchdog
- `run_cycles` out 32: cycle count of the last or current run
- `proc_rstN` out 1: processor reset, active-low
- `proc_start` out 1: processor start
- `proc_done` in 1: processor done
- `proc_ins_addr` in INS_MEM_ADDR_WIDTH: processor instruction address
- `proc_data_addr` in DATA_MEM_ADDR_WIDTH: processor data address
- `proc_data_wr_en` in 1: processor data write enable
- `proc_data_out` in DW: processor write data
- `imem_addr`, `imem_wr_en`, `imem_wdata` out: instruction memory port (widths INS_MEM_ADDR_WIDTH, 1, INS_WIDTH)
- `dmem_addr`, `dmem_wr_en`, `dmem_wdata` out: data memory port (widths DATA_MEM_ADDR_WIDTH, 1, DW)
- `dmem_rdata` in DW: data memory read data, 1-cycle synchronous read

The processor's data input is wired directly to `dmem_rdata` outside this block.

## Operation
States: IDLE, RD_WAIT, RUN.

**IDLE**
- `host_ready`=1, `proc_rstN`=0, `proc_start`=0.
- Memory ports are host-owned.
- When no transaction is accepted, write enables are 0 and addresses hold their last values.
- On an accepted transaction:
  - LOAD_INS: `imem_wr_en`=1 combinationally, `imem_addr`/`imem_wdata` from host. Stay in IDLE, so back-to-back writes run at 1 per cycle.
  - LOAD_DATA: same behaviour on the data memory port. Stay in IDLE.
  - READ_DATA: `dmem_addr`=`host_addr`, `dmem_wr_en`=0. Go to RD_WAIT.
  - RUN: clear `run_done`, `run_timeout` and `run_cycles`. Go to RUN.

**RD_WAIT**
- `host_ready`=0, `host_rvalid`=1.
- `host_rdata`=`dmem_rdata`; `host_rdata` is 0 whenever `host_rvalid`=0.
- Always returns to IDLE next cycle.

**RUN**
- `host_ready`=0, `proc_rstN`=1, `proc_start`=1.
- Ports are processor-owned: `imem_addr`=`proc_ins_addr`, `dmem_addr`=`proc_data_addr`, `dmem_wr_en`=`proc_data_wr_en`, `dmem_wdata`=`proc_data_out`, `imem_wr_en`=0.
- `proc_done`=1: set `run_done`, go to IDLE. `run_cycles` is not incremented.
- Otherwise, if `run_cycles == TIMEOUT_CYCLES-1`: set `run_timeout`, go to IDLE.
- Otherwise: `run_cycles` increments by 1.

**Rules**
- `proc_done` and the timeout in the same cycle: done wins. Only `run_done` is set.
- `run_cycles` equals the number of RUN cycles before done was seen. It is frozen outside RUN and never wraps, because the timeout bounds it.
- `host_op` and `host_wdata` are ignored while `host_ready`=0.
- Returning to IDLE re-asserts the processor reset (`proc_rstN`=0) the next cycle. This aborts a timed-out processor cleanly.

## Timing
- Reset values:
  - state IDLE
  - `host_ready`=0 while `rst` is high, 1 in the first cycle after release
  - all other outputs 0, including `proc_rstN`=0 and `run_cycles`=0
- `rst` asserted mid-RUN or mid-RD_WAIT: immediate return to IDLE values. No `host_rvalid` is issued and `run_done` is not set.
- Host write latency: the memory write happens on the same edge that accepts the transaction.
- Read latency: READ_DATA accepted at edge T; `host_rvalid`/`host_rdata` are valid in the cycle after T. The next transaction can be accepted at T+2.
- RUN latency: RUN accepted at edge T; `proc_rstN` and `proc_start` rise in cycle T+1. They fall in the cycle after `proc_done` is sampled high.

## Test plan
- **Load and read back:** LOAD_DATA addr 0x005 data 0x123456789ABC, then READ_DATA addr 0x005 → `host_rvalid` one cycle later with 0x123456789ABC. `host_ready` is low for exactly 1 cycle.
- **Burst instruction load:** LOAD_INS addrs 0..3 on 4 consecutive cycles → 4 `imem_wr_en` pulses with matching addr/data. `host_ready` stays 1 throughout.
- **Normal run:** RUN with `proc_done` raised on the 10th RUN cycle → `run_done`=1, `run_cycles`=9, `proc_start` low next cycle. The bench confirms processor-driven `dmem_wr_en` passes through during RUN.
- **Timeout:** TIMEOUT_CYCLES=16, `proc_done` tied 0 → exit after 16 RUN cycles, `run_timeout`=1, `run_done`=0, `run_cycles`=15, `proc_rstN`=0.
- **Done on the timeout cycle:** TIMEOUT_CYCLES=16, `proc_done` on the 16th RUN cycle → `run_done`=1, `run_timeout`=0.
- **Reset mid-run:** `rst` pulsed during RUN → all outputs at reset values immediately. After release the controller accepts a new LOAD_DATA.

Source files
------------

// File: rtl/processor_host_controller.sv
// rtl/processor_host_controller.sv - host/processor sequencer arbitrating instruction and data memory ports
//
// Purpose: owns the instruction and data memory ports on behalf of the host
// while idle (program/data load, result readback), hands them to the
// processor during a run, and reports completion, cycle count and watchdog
// timeout.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   host_valid/host_ready          host transaction handshake
//   host_op/host_addr/host_wdata   transaction opcode, address, write data
//   host_rdata/host_rvalid         READ_DATA response (one-cycle pulse)
//   busy                           controller not in IDLE
//   run_done/run_timeout           sticky run outcome flags
//   run_cycles                     cycle count of last or current run
//   proc_rstN/proc_start           processor reset (active-low) and start
//   proc_done, proc_*              processor status and memory requests
//   imem_*                         instruction memory port
//   dmem_*                         data memory port (1-cycle synchronous read)
module processor_host_controller #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 4,
  parameter int INS_WIDTH           = 8,
  parameter int INS_MEM_ADDR_WIDTH  = 8,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES      = 1000000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                host_valid,
  output logic                                host_ready,
  input  logic [1:0]                          host_op,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      host_addr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     host_wdata,
  output logic [REG_WIDTH*CORE_COUNT-1:0]     host_rdata,
  output logic                                host_rvalid,
  output logic                                busy,
  output logic                                run_done,
  output logic                                run_timeout,
  output logic [31:0]                         run_cycles,
  output logic                                proc_rstN,
  output logic                                proc_start,
  input  logic                                proc_done,
  input  logic [INS_MEM_ADDR_WIDTH-1:0]       proc_ins_addr,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      proc_data_addr,
  input  logic                                proc_data_wr_en,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     proc_data_out,
  output logic [INS_MEM_ADDR_WIDTH-1:0]       imem_addr,
  output logic                                imem_wr_en,
  output logic [INS_WIDTH-1:0]                imem_wdata,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      dmem_addr,
  output logic                                dmem_wr_en,
  output logic [REG_WIDTH*CORE_COUNT-1:0]     dmem_wdata,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     dmem_rdata
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_LOAD_INS  = 2'b00;
  localparam logic [1:0] OP_LOAD_DATA = 2'b01;
  localparam logic [1:0] OP_RUN       = 2'b10;
  localparam logic [1:0] OP_READ_DATA = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RUN} state_t;

  state_t                           state_q, state_d;
  logic                             run_done_q, run_done_d;
  logic                             run_timeout_q, run_timeout_d;
  logic [31:0]                      run_cycles_q, run_cycles_d;
  // Last driven addresses, so idle ports hold rather than glitch to 0.
  logic [INS_MEM_ADDR_WIDTH-1:0]    imem_addr_q;
  logic [DATA_MEM_ADDR_WIDTH-1:0]   dmem_addr_q;
  logic                             accept;

  // Gating with rst keeps host_ready low for the whole reset pulse.
  assign host_ready  = (state_q == S_IDLE) && !rst;
  assign accept      = host_valid && host_ready;
  assign busy        = (state_q != S_IDLE);
  assign run_done    = run_done_q;
  assign run_timeout = run_timeout_q;
  assign run_cycles  = run_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      run_done_q    <= 1'b0;
      run_timeout_q <= 1'b0;
      run_cycles_q  <= '0;
      imem_addr_q   <= '0;
      dmem_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      run_done_q    <= run_done_d;
      run_timeout_q <= run_timeout_d;
      run_cycles_q  <= run_cycles_d;
      imem_addr_q   <= imem_addr;
      dmem_addr_q   <= dmem_addr;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_done_d    = run_done_q;
    run_timeout_d = run_timeout_q;
    run_cycles_d  = run_cycles_q;
    imem_addr     = imem_addr_q;
    imem_wr_en    = 1'b0;
    imem_wdata    = '0;
    dmem_addr     = dmem_addr_q;
    dmem_wr_en    = 1'b0;
    dmem_wdata    = '0;
    host_rvalid   = 1'b0;
    host_rdata    = '0;
    proc_rstN     = 1'b0;
    proc_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (host_op)
            OP_LOAD_INS: begin
              imem_wr_en = 1'b1;
              imem_addr  = host_addr[INS_MEM_ADDR_WIDTH-1:0];
              imem_wdata = host_wdata[INS_WIDTH-1:0];
            end
            OP_LOAD_DATA: begin
              dmem_wr_en = 1'b1;
              dmem_addr  = host_addr;
              dmem_wdata = host_wdata;
            end
            OP_RUN: begin
              run_done_d    = 1'b0;
              run_timeout_d = 1'b0;
              run_cycles_d  = '0;
              state_d       = S_RUN;
            end
            OP_READ_DATA: begin
              dmem_addr = host_addr;
              state_d   = S_RD_WAIT;
            end
            default: ;
          endcase
        end
      end

      S_RD_WAIT: begin
        // Memory read issued on the accepting edge is visible now.
        host_rvalid = 1'b1;
        host_rdata  = dmem_rdata;
        state_d     = S_IDLE;
      end

      S_RUN: begin
        proc_rstN  = 1'b1;
        proc_start = 1'b1;
        imem_addr  = proc_ins_addr;
        dmem_addr  = proc_data_addr;
        dmem_wr_en = proc_data_wr_en;
        dmem_wdata = proc_data_out;
        // Done takes priority over a coincident watchdog expiry.
        if (proc_done) begin
          run_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (run_cycles_q == TIMEOUT_LAST) begin
          run_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_processor_host_controller.sv
// tb/tb_processor_host_controller.sv - scoreboard bench for processor_host_controller
module tb_processor_host_controller;

  localparam int DW  = 48;
  localparam int IW  = 8;
  localparam int IAW = 8;
  localparam int DAW = 12;
  localparam int TO  = 16;

  logic            clk, rst;
  logic            host_valid, host_ready;
  logic [1:0]      host_op;
  logic [DAW-1:0]  host_addr;
  logic [DW-1:0]   host_wdata, host_rdata;
  logic            host_rvalid, busy, run_done, run_timeout;
  logic [31:0]     run_cycles;
  logic            proc_rstN, proc_start, proc_done;
  logic [IAW-1:0]  proc_ins_addr;
  logic [DAW-1:0]  proc_data_addr;
  logic            proc_data_wr_en;
  logic [DW-1:0]   proc_data_out;
  logic [IAW-1:0]  imem_addr;
  logic            imem_wr_en;
  logic [IW-1:0]   imem_wdata;
  logic [DAW-1:0]  dmem_addr;
  logic            dmem_wr_en;
  logic [DW-1:0]   dmem_wdata, dmem_rdata;

  processor_host_controller #(
    .REG_WIDTH(12), .CORE_COUNT(4), .INS_WIDTH(IW), .INS_MEM_ADDR_WIDTH(IAW),
    .DATA_MEM_ADDR_WIDTH(DAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_op(host_op), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .busy(busy),
    .run_done(run_done), .run_timeout(run_timeout), .run_cycles(run_cycles),
    .proc_rstN(proc_rstN), .proc_start(proc_start), .proc_done(proc_done),
    .proc_ins_addr(proc_ins_addr), .proc_data_addr(proc_data_addr),
    .proc_data_wr_en(proc_data_wr_en), .proc_data_out(proc_data_out),
    .imem_addr(imem_addr), .imem_wr_en(imem_wr_en), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical data memory attached to the DUT ports.
  logic [DW-1:0] dmem [0:4095];
  always @(posedge clk) begin
    if (dmem_wr_en) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  // Reference model: what memory should contain after each host/processor write.
  logic [DW-1:0] ref_mem [0:4095];

  typedef struct {bit done; bit to; int cycles;} run_exp_t;
  logic [DW-1:0]     rd_q[$];
  logic [IAW+IW-1:0] ins_q[$];
  run_exp_t          run_q[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents a response.
  logic          prev_start = 1'b0;
  logic [DW-1:0] exp_rd;
  logic [IAW+IW-1:0] exp_ins;
  run_exp_t      exp_run;
  always @(negedge clk) begin
    if (!rst) begin
      if (host_rvalid) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          exp_rd = rd_q.pop_front();
          check("host_rdata", host_rdata, exp_rd);
          check("ready_low_rd_wait", host_ready, 0);
        end
      end else begin
        check("rdata_zero_idle", host_rdata, 0);
      end
      if (imem_wr_en) begin
        if (ins_q.size() == 0) check("unexpected_imem_wr", 1, 0);
        else begin
          exp_ins = ins_q.pop_front();
          check("imem_addr_data", {imem_addr, imem_wdata}, exp_ins);
        end
      end
      if (proc_start) begin
        check("pass_dmem_wr_en", dmem_wr_en, proc_data_wr_en);
        check("pass_dmem_addr", dmem_addr, proc_data_addr);
        check("pass_imem_wr_en", imem_wr_en, 0);
      end
      if (prev_start && !proc_start) begin
        if (run_q.size() == 0) check("unexpected_run_end", 1, 0);
        else begin
          exp_run = run_q.pop_front();
          check("run_done", run_done, exp_run.done);
          check("run_timeout", run_timeout, exp_run.to);
          check("run_cycles", run_cycles, exp_run.cycles);
          check("proc_rstN_after_run", proc_rstN, 0);
        end
      end
    end
    prev_start = proc_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one host transaction; the reference model is updated at issue time.
  task automatic txn(input logic [1:0] op, input logic [DAW-1:0] addr, input logic [DW-1:0] wd);
    int guard = 0;
    host_valid = 1'b1; host_op = op; host_addr = addr; host_wdata = wd;
    while (!host_ready && guard < 50) begin tick(); guard++; end
    if (!host_ready) begin
      check("host_ready_wait", 0, 1);
      host_valid = 1'b0;
      return;
    end
    case (op)
      2'b00: ins_q.push_back({addr[IAW-1:0], wd[IW-1:0]});
      2'b01: ref_mem[addr] = wd;
      2'b11: rd_q.push_back(ref_mem[addr]);
      default: ;
    endcase
    tick();
    host_valid = 1'b0;
    host_op = 2'($urandom);
    host_wdata = DW'({$urandom(), $urandom()});
  endtask

  // n = cycle (1-based) on which the processor raises done; 0 = never.
  task automatic do_run(input int n);
    int k = 0;
    int lim;
    run_exp_t e;
    e.done   = (n >= 1 && n <= TO);
    e.to     = !e.done;
    e.cycles = e.done ? n - 1 : TO - 1;
    lim      = e.done ? n : TO;
    run_q.push_back(e);
    txn(2'b10, '0, '0);
    while (proc_start && k < TO + 5) begin
      k++;
      proc_done       = (k == n);
      proc_data_wr_en = 1'($urandom);
      proc_data_addr  = DAW'($urandom_range(0, 31));
      proc_data_out   = DW'({$urandom(), $urandom()});
      proc_ins_addr   = IAW'($urandom);
      if (proc_data_wr_en) ref_mem[proc_data_addr] = proc_data_out;
      tick();
    end
    proc_done = 1'b0;
    proc_data_wr_en = 1'b0;
    check("run_length", k, lim);
    check("proc_start_low_after", proc_start, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; host_valid = 1'b0; host_op = '0; host_addr = '0; host_wdata = '0;
    proc_done = 1'b0; proc_ins_addr = '0; proc_data_addr = '0;
    proc_data_wr_en = 1'b0; proc_data_out = '0;
    tick(); tick();
    check("rst_host_ready", host_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_proc_rstN", proc_rstN, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_flags", {run_done, run_timeout, proc_start}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_release", host_ready, 1);

    // Load and read back
    txn(2'b01, 12'h005, 48'h123456789ABC);
    txn(2'b11, 12'h005, '0);
    check("ready_low_one_cycle", host_ready, 0);
    tick();
    check("ready_back_high", host_ready, 1);

    // Burst instruction load
    for (int i = 0; i < 4; i++) begin
      check("burst_ready_high", host_ready, 1);
      txn(2'b00, DAW'(i), DW'($urandom));
    end

    do_run(10);
    do_run(0);
    do_run(16);
    for (int a = 0; a < 32; a++) txn(2'b11, DAW'(a), '0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: txn(2'b00, DAW'($urandom), DW'({$urandom(), $urandom()}));
        1: txn(2'b01, DAW'($urandom_range(0, 31)), DW'({$urandom(), $urandom()}));
        2: do_run(int'($urandom_range(0, 20)));
        default: txn(2'b11, DAW'($urandom_range(0, 31)), '0);
      endcase
    end

    // Reset mid-run
    txn(2'b10, '0, '0);
    repeat (5) tick();
    check("midrun_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_outputs",
          {host_ready, busy, proc_rstN, proc_start, run_done, run_timeout, host_rvalid, dmem_wr_en, imem_wr_en}, 0);
    check("midrun_rst_cycles", run_cycles, 0);
    tick();
    rst = 1'b0;
    #1;
    txn(2'b01, 12'h0AA, 48'hFEDCBA987654);
    txn(2'b11, 12'h0AA, '0);
    repeat (3) tick();

    check("rd_q_drained", rd_q.size(), 0);
    check("ins_q_drained", ins_q.size(), 0);
    check("run_q_drained", run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
